// File: rtl/mx_stim_pkg.sv
// Shared types and constants for the MX FP32 stimulus generator: corner-case modes,
// FP32 field layout, LFSR constants and the per-element formatting helper.
package mx_stim_pkg;

    typedef enum logic [2:0] {
        MODE_RANDOM     = 3'd0,
        MODE_CARRY      = 3'd1,
        MODE_TIE        = 3'd2,
        MODE_MAN_OVF    = 3'd3,
        MODE_SCALAR_OVF = 3'd4,
        MODE_NAN        = 3'd5,
        MODE_SUBNORMAL  = 3'd6,
        MODE_SWEEP      = 3'd7
    } mx_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } stim_state_e;

    localparam int FP32_W   = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int MAN_LSB  = 0;
    localparam int EXP_LSB  = 23;
    localparam int SIGN_BIT = 31;

    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [31:0] GOLDEN_SEED = 32'h9E37_79B9;

    localparam logic [EXP_W-1:0] EXP_MIN_BLK    = 8'd1;
    localparam logic [EXP_W-1:0] EXP_MAX_BLK    = 8'd253;
    localparam logic [EXP_W-1:0] EXP_SCALAR_OVF = 8'd254;
    localparam logic [EXP_W-1:0] EXP_NAN        = 8'd255;

    function automatic logic [EXP_W-1:0] clamp_exp(input logic [EXP_W-1:0] x);
        if (x < EXP_MIN_BLK)      return EXP_MIN_BLK;
        else if (x > EXP_MAX_BLK) return EXP_MAX_BLK;
        else                      return x;
    endfunction

    // Mantissa randomness comes from r[31:9]; r[2:0] is the RANDOM-mode exponent offset.
    function automatic logic [FP32_W-1:0] make_elem(input mx_mode_e         mode,
                                                    input logic             sign,
                                                    input logic [EXP_W-1:0] e_blk,
                                                    input logic [31:0]      r);
        logic [MAN_W-1:0] mr;
        logic [EXP_W-1:0] ex;
        logic [MAN_W-1:0] man;
        mr = r[31:9];
        case (mode)
            MODE_RANDOM: begin
                ex  = (e_blk > {5'd0, r[2:0]}) ? e_blk - {5'd0, r[2:0]} : EXP_MIN_BLK;
                man = mr;
            end
            MODE_CARRY: begin
                ex  = e_blk;
                man = {(&mr[22:17]) ? {mr[22:18], 1'b0} : mr[22:17], 1'b1, mr[15:1], 1'b1};
            end
            MODE_TIE: begin
                ex  = e_blk;
                man = {mr[22:17], 1'b1, 16'h0000};
            end
            MODE_MAN_OVF: begin
                ex  = e_blk;
                man = {6'h3F, 1'b1, mr[15:0]};
            end
            MODE_SCALAR_OVF: begin
                ex  = EXP_SCALAR_OVF;
                man = {6'h3F, 1'b1, mr[15:0]};
            end
            MODE_NAN: begin
                ex  = EXP_NAN;
                man = {1'b1, mr[21:0]};
            end
            MODE_SUBNORMAL: begin
                ex  = '0;
                man = mr | {22'd0, (mr == '0)};
            end
            default: begin
                ex  = e_blk;
                man = mr;
            end
        endcase
        return {sign, ex, man};
    endfunction

endpackage

// File: rtl/mx_lfsr32.sv
// One 32-bit right-shifting Galois LFSR; it steps only when advance is high.
module mx_lfsr32
    import mx_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] seed_nz;
    assign seed_nz = (seed == 32'd0) ? 32'd1 : seed;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; a blocking assignment here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= seed_nz;
        end else if (advance) begin
            value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_POLY : 32'd0);
        end
    end

endmodule

// File: rtl/mx_fp32_stim_gen.sv
// MX-block FP32 stimulus generator: emits num_blocks blocks of BLOCK_SIZE elements,
// LANES per beat, with a shared per-block exponent and selectable corner-case mantissas.
module mx_fp32_stim_gen
    import mx_stim_pkg::*;
#(
    parameter int          LANES      = 4,
    parameter int          BLOCK_SIZE = 32,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            mode_i,
    input  logic [15:0]           num_blocks_i,
    input  logic                  ready_i,
    output logic [LANES*32-1:0]   data_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic [2:0]            mode_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int          BEATS     = BLOCK_SIZE / LANES;
    localparam logic [15:0] LAST_BEAT = 16'(BEATS - 1);

    stim_state_e      state;
    mx_mode_e         mode_q;
    logic             sweep_q;
    logic [15:0]      num_q;
    logic [15:0]      blk_cnt;
    logic [15:0]      beat_cnt;
    logic [EXP_W-1:0] e_blk_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [31:0]        lfsr_val [LANES];
    logic               accept;
    logic               is_first_beat;
    logic               is_last_beat;
    logic               is_last_blk;
    logic [EXP_W-1:0]   e_first;
    logic [EXP_W-1:0]   e_cur;
    logic [LANES*32-1:0] beat_data;

    assign accept        = valid_q & ready_i;
    assign is_first_beat = (beat_cnt == 16'd0);
    assign is_last_beat  = (beat_cnt == LAST_BEAT);
    assign is_last_blk   = (blk_cnt == 16'(num_q - 16'd1));
    assign e_first       = clamp_exp(lfsr_val[0][7:0]);
    assign e_cur         = is_first_beat ? e_first : e_blk_q;

    // LFSRs step only on accepted beats, so a stalled beat stays bit-identical.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [31:0] LANE_SEED = SEED ^ (32'(l) * GOLDEN_SEED);
        mx_lfsr32 u_lfsr (
            .clk     (clk),
            .rst     (rst),
            .seed    (LANE_SEED),
            .advance (accept),
            .value   (lfsr_val[l])
        );
    end

    // NOTE: every output of this always_comb is assigned before any conditional use,
    // which keeps the block purely combinational with no inferred latch.
    always_comb begin
        beat_data = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_data[32*l +: 32] = make_elem(mode_q, blk_cnt[0], e_cur, lfsr_val[l]);
        end
    end

    assign data_o  = valid_q ? beat_data : '0;
    assign valid_o = valid_q;
    assign last_o  = valid_q & is_last_beat;
    assign mode_o  = valid_q ? mode_q : 3'd0;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_RANDOM;
            sweep_q  <= 1'b0;
            num_q    <= '0;
            blk_cnt  <= '0;
            beat_cnt <= '0;
            e_blk_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        num_q    <= num_blocks_i;
                        sweep_q  <= (mode_i == MODE_SWEEP);
                        mode_q   <= (mode_i == MODE_SWEEP) ? MODE_RANDOM : mx_mode_e'(mode_i);
                        blk_cnt  <= '0;
                        beat_cnt <= '0;
                        busy_q   <= 1'b1;
                        if (num_blocks_i != 16'd0) begin
                            state   <= ST_RUN;
                            valid_q <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (is_first_beat) e_blk_q <= e_first;
                        if (is_last_beat) begin
                            beat_cnt <= '0;
                            if (is_last_blk) begin
                                state   <= ST_DONE;
                                valid_q <= 1'b0;
                            end else begin
                                blk_cnt <= blk_cnt + 16'd1;
                                if (sweep_q) begin
                                    mode_q <= (mode_q == MODE_SUBNORMAL) ? MODE_RANDOM
                                                                         : mx_mode_e'(3'(mode_q) + 3'd1);
                                end
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mx_fp32_stim_gen.sv
// Directed self-checking bench for mx_fp32_stim_gen with a reference LFSR/element model.
module tb_mx_fp32_stim_gen;

    localparam int LANES      = 4;
    localparam int BLOCK_SIZE = 32;
    localparam int BEATS      = BLOCK_SIZE / LANES;
    localparam int MAX_CYC    = 1000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_i;
    logic [2:0]           mode_i;
    logic [15:0]          num_blocks_i;
    logic                 ready_i;
    logic [LANES*32-1:0]  data_o;
    logic                 valid_o;
    logic                 last_o;
    logic [2:0]           mode_o;
    logic                 busy_o;
    logic                 done_o;

    always #5 clk = ~clk;

    mx_fp32_stim_gen #(
        .LANES      (LANES),
        .BLOCK_SIZE (BLOCK_SIZE),
        .SEED       (32'h1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .num_blocks_i (num_blocks_i),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .last_o       (last_o),
        .mode_o       (mode_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  mdl [LANES];
    logic [127:0] cap [BEATS];
    int           cap_n = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic mdl_reseed();
        logic [31:0] s;
        for (int l = 0; l < LANES; l++) begin
            s = 32'h1 ^ (32'(l) * 32'h9E3779B9);
            mdl[l] = (s == 32'd0) ? 32'd1 : s;
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    endfunction

    function automatic logic [7:0] clamp8(input logic [7:0] x);
        if (x == 8'd0)  return 8'd1;
        if (x > 8'd253) return 8'd253;
        return x;
    endfunction

    function automatic logic [31:0] exp_elem(input int mode, input logic sign,
                                             input logic [7:0] e, input logic [31:0] r);
        logic [22:0] rm;
        logic [5:0]  keep;
        logic [7:0]  ex;
        logic [22:0] man;
        rm = r[31:9];
        case (mode)
            0: begin ex = (e > {5'd0, r[2:0]}) ? e - {5'd0, r[2:0]} : 8'd1; man = rm; end
            1: begin
                keep = rm[22:17];
                if (keep == 6'h3F) keep = 6'h3E;
                ex = e; man = {keep, 1'b1, rm[15:1], 1'b1};
            end
            2: begin ex = e;      man = {rm[22:17], 1'b1, 16'h0}; end
            3: begin ex = e;      man = {6'h3F, 1'b1, rm[15:0]}; end
            4: begin ex = 8'd254; man = {6'h3F, 1'b1, rm[15:0]}; end
            5: begin ex = 8'hFF;  man = {1'b1, rm[21:0]}; end
            default: begin ex = 8'd0; man = (rm == 23'd0) ? 23'd1 : rm; end
        endcase
        return {sign, ex, man};
    endfunction

    // Drives one run and checks each beat; abort_at >= 0 asserts rst on that beat.
    task automatic run(input int mode, input int nblk, input bit stall,
                       input int abort_at, input bit capture, input bit compare);
        int           beats, cyc, blk, bib, eff, total;
        logic [7:0]   eblk;
        logic [127:0] expd, prev;
        logic [31:0]  x;
        bit           prev_stall, ok;
        total = nblk * BEATS;
        eblk  = 8'd0;
        prev  = '0;
        @(negedge clk);
        start_i      = 1'b1;
        mode_i       = mode[2:0];
        num_blocks_i = nblk[15:0];
        @(negedge clk);
        start_i    = 1'b0;
        beats      = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        while (beats < total && cyc < MAX_CYC) begin
            if (abort_at >= 0 && beats == abort_at) begin
                start_i = 1'b0;
                rst     = 1'b1;
                #1;
                check("abort_data", data_o, '0);
                check("abort_ctl", {valid_o, last_o, mode_o, busy_o, done_o}, '0);
                mdl_reseed();
                return;
            end
            start_i = (cyc == 2);
            ready_i = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            blk = beats / BEATS;
            bib = beats % BEATS;
            eff = (mode == 7) ? blk % 7 : mode;
            if (bib == 0) eblk = clamp8(mdl[0][7:0]);
            for (int l = 0; l < LANES; l++) expd[32*l +: 32] = exp_elem(eff, blk[0], eblk, mdl[l]);
            check("valid", valid_o, 1'b1);
            check("data", data_o, expd);
            check("last", last_o, bib == BEATS - 1);
            check("mode", mode_o, eff[2:0]);
            if (prev_stall) check("stall_hold", data_o, prev);
            ok = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                x = data_o[32*l +: 32];
                if (x[31] != blk[0]) ok = 1'b0;
                case (eff)
                    0: if (x[30:23] < 8'd1 || x[30:23] > 8'd253) ok = 1'b0;
                    1: if (!x[16] || x[15:0] == 16'd0 || x[22:17] == 6'h3F || x[30:23] != eblk) ok = 1'b0;
                    2: if (!x[16] || x[15:0] != 16'd0 || x[30:23] != eblk) ok = 1'b0;
                    3: if (x[22:16] != 7'h7F || x[30:23] != eblk) ok = 1'b0;
                    4: if (x[22:16] != 7'h7F || x[30:23] != 8'd254) ok = 1'b0;
                    5: if (x != 32'h7FC00000 && !(x[30:23] == 8'hFF && x[22])) ok = 1'b0;
                    default: if (x[30:23] != 8'd0 || x[22:0] == 23'd0) ok = 1'b0;
                endcase
            end
            check("props", ok, 1'b1);
            if (capture && beats < BEATS) begin
                cap[beats] = data_o;
                if (beats + 1 > cap_n) cap_n = beats + 1;
            end
            if (compare && beats < cap_n) check("rerun", data_o, cap[beats]);
            prev       = data_o;
            prev_stall = !ready_i;
            if (ready_i) begin
                for (int l = 0; l < LANES; l++) mdl[l] = lfsr_step(mdl[l]);
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        check("timeout", cyc < MAX_CYC, 1'b1);
        check("end_ctl", {valid_o, busy_o, done_o}, 3'b010);
        @(negedge clk);
        check("done_pulse", {valid_o, busy_o, done_o}, 3'b001);
        @(negedge clk);
        check("idle", {busy_o, done_o}, 2'b00);
    endtask

    initial begin
        int dones, vals;
        rst          = 1'b1;
        start_i      = 1'b0;
        mode_i       = 3'd0;
        num_blocks_i = 16'd0;
        ready_i      = 1'b1;
        mdl_reseed();
        @(negedge clk);
        check("reset_data", data_o, '0);
        check("reset_ctl", {valid_o, last_o, mode_o, busy_o, done_o}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Aborted run, then a rerun from reset that must repeat the captured beats.
        run(0, 1, 1'b0, 3, 1'b1, 1'b0);
        @(negedge clk);
        check("abort_hold", {valid_o, busy_o, done_o}, 3'b000);
        rst   = 1'b0;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("abort_no_done", dones, 0);
        check("capture_len", cap_n, 3);

        run(0, 2, 1'b0, -1, 1'b0, 1'b1);
        run(1, 1, 1'b0, -1, 1'b0, 1'b0);
        run(5, 1, 1'b1, -1, 1'b0, 1'b0);
        run(2, 1, 1'b0, -1, 1'b0, 1'b0);
        run(3, 1, 1'b1, -1, 1'b0, 1'b0);
        run(7, 7, 1'b0, -1, 1'b0, 1'b0);

        // Zero-block run: straight to DONE, one done pulse, never valid.
        @(negedge clk);
        start_i      = 1'b1;
        mode_i       = 3'd0;
        num_blocks_i = 16'd0;
        @(negedge clk);
        start_i = 1'b0;
        dones   = 0;
        vals    = 0;
        repeat (6) begin
            if (done_o)  dones++;
            if (valid_o) vals++;
            @(negedge clk);
        end
        check("zero_valid", vals, 0);
        check("zero_done", dones, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
